// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: two-port arbiter/sequencer in front of the single-port DTCM macro.
// Port 0 (load/store unit) has priority; port 1 (debug/external bus) is guaranteed
// a grant after STARVE_MAX consecutive contended losses. One command is in flight
// at a time; an unconsumed response is parked in a hold register.
module dtcm_arbiter #(
  parameter int unsigned AW         = 14,
  parameter int unsigned DW         = 32,
  parameter int unsigned MW         = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,

  // Port 0: core load/store unit
  input  logic          m0_cmd_valid_i,
  output logic          m0_cmd_ready_o,
  input  logic          m0_cmd_read_i,
  input  logic [AW-1:0] m0_cmd_addr_i,
  input  logic [DW-1:0] m0_cmd_wdata_i,
  input  logic [MW-1:0] m0_cmd_wmask_i,
  output logic          m0_rsp_valid_o,
  input  logic          m0_rsp_ready_i,
  output logic [DW-1:0] m0_rsp_rdata_o,

  // Port 1: external/debug bus
  input  logic          m1_cmd_valid_i,
  output logic          m1_cmd_ready_o,
  input  logic          m1_cmd_read_i,
  input  logic [AW-1:0] m1_cmd_addr_i,
  input  logic [DW-1:0] m1_cmd_wdata_i,
  input  logic [MW-1:0] m1_cmd_wmask_i,
  output logic          m1_rsp_valid_o,
  input  logic          m1_rsp_ready_i,
  output logic [DW-1:0] m1_rsp_rdata_o,

  // RAM macro
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  output logic [MW-1:0] ram_wem_o,
  input  logic [DW-1:0] ram_dout_i
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  // Pipeline state
  logic          infl_q, infl_d;
  logic          infl_owner_q, infl_owner_d;
  logic          infl_read_q, infl_read_d;
  logic          hold_q, hold_d;
  logic          hold_owner_q, hold_owner_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;

  // Arbitration signals
  logic          infl_rsp_ready;
  logic          can_issue;
  logic          starve_hit;
  logic          rdy0, rdy1;
  logic          acc0, acc1, acc;

  // Selected command
  logic          sel_read;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmask;

  // Response presentation
  logic [DW-1:0] live_data;
  logic          pres_valid;
  logic          pres_owner;
  logic [DW-1:0] pres_data;
  logic          pres_ready;

  // Issue slot and grant decision; readiness never looks at the port's own valid.
  always_comb begin
    infl_rsp_ready = infl_owner_q ? m1_rsp_ready_i : m0_rsp_ready_i;
    can_issue      = !rst && !hold_q && (!infl_q || infl_rsp_ready);
    starve_hit     = (starve_cnt_q == StarveMax);
    rdy0           = can_issue && !(m1_cmd_valid_i && starve_hit);
    rdy1           = can_issue && (!m0_cmd_valid_i || starve_hit);
    acc0           = m0_cmd_valid_i && rdy0;
    acc1           = m1_cmd_valid_i && rdy1;
    acc            = acc0 || acc1;
  end

  assign m0_cmd_ready_o = rdy0;
  assign m1_cmd_ready_o = rdy1;

  // Winner command mux (acc0 and acc1 are mutually exclusive).
  always_comb begin
    sel_read  = m0_cmd_read_i;
    sel_addr  = m0_cmd_addr_i;
    sel_wdata = m0_cmd_wdata_i;
    sel_wmask = m0_cmd_wmask_i;
    if (acc1) begin
      sel_read  = m1_cmd_read_i;
      sel_addr  = m1_cmd_addr_i;
      sel_wdata = m1_cmd_wdata_i;
      sel_wmask = m1_cmd_wmask_i;
    end
  end

  // RAM drive; address is held when idle so a parked read result is not disturbed.
  always_comb begin
    ram_we_o   = 1'b0;
    ram_addr_o = ram_addr_q;
    ram_din_o  = '0;
    ram_wem_o  = '0;
    if (acc) begin
      ram_we_o   = !sel_read;
      ram_addr_o = sel_addr;
      ram_din_o  = sel_wdata;
      ram_wem_o  = sel_read ? '0 : sel_wmask;
    end
    ram_addr_d = ram_addr_o;
  end

  // Response source: the hold register wins over the in-flight (live RAM) response.
  always_comb begin
    live_data  = infl_read_q ? ram_dout_i : '0;
    pres_valid = hold_q || infl_q;
    pres_owner = hold_q ? hold_owner_q : infl_owner_q;
    pres_data  = hold_q ? hold_data_q : live_data;
    pres_ready = pres_owner ? m1_rsp_ready_i : m0_rsp_ready_i;

    m0_rsp_valid_o = pres_valid && !pres_owner;
    m1_rsp_valid_o = pres_valid && pres_owner;
    m0_rsp_rdata_o = (pres_valid && !pres_owner) ? pres_data : '0;
    m1_rsp_rdata_o = (pres_valid && pres_owner) ? pres_data : '0;
  end

  // Next-state for the in-flight slot and the hold register.
  always_comb begin
    infl_d       = acc;
    infl_owner_d = acc ? acc1 : infl_owner_q;
    infl_read_d  = acc ? sel_read : infl_read_q;
    hold_d       = hold_q;
    hold_owner_d = hold_owner_q;
    hold_data_d  = hold_data_q;
    if (hold_q) begin
      if (pres_ready) begin
        hold_d = 1'b0;
      end
    end else if (infl_q && !infl_rsp_ready) begin
      // The RAM output is only valid for one cycle; park it.
      hold_d       = 1'b1;
      hold_owner_d = infl_owner_q;
      hold_data_d  = live_data;
    end
  end

  // Starvation counter: counts contended losses of port 1, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (m0_cmd_valid_i && m1_cmd_valid_i && can_issue && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end else if (acc1 || !m1_cmd_valid_i) begin
      starve_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q       <= 1'b0;
      infl_owner_q <= 1'b0;
      infl_read_q  <= 1'b0;
      hold_q       <= 1'b0;
      hold_owner_q <= 1'b0;
      hold_data_q  <= '0;
      starve_cnt_q <= '0;
      ram_addr_q   <= '0;
    end else begin
      infl_q       <= infl_d;
      infl_owner_q <= infl_owner_d;
      infl_read_q  <= infl_read_d;
      hold_q       <= hold_d;
      hold_owner_q <= hold_owner_d;
      hold_data_q  <= hold_data_d;
      starve_cnt_q <= starve_cnt_d;
      ram_addr_q   <= ram_addr_d;
    end
  end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter: directed vector table, hand sequences for
// starvation/streaming/reset, and random traffic against a transaction-level model.
module tb_dtcm_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [13:0] m0_cmd_addr;
  logic [31:0] m0_cmd_wdata;
  logic [3:0]  m0_cmd_wmask;
  logic        m0_rsp_valid, m0_rsp_ready;
  logic [31:0] m0_rsp_rdata;
  logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [13:0] m1_cmd_addr;
  logic [31:0] m1_cmd_wdata;
  logic [3:0]  m1_cmd_wmask;
  logic        m1_rsp_valid, m1_rsp_ready;
  logic [31:0] m1_rsp_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  dtcm_arbiter #(
    .AW(14), .DW(32), .MW(4), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_cmd_valid_i (m0_cmd_valid),
    .m0_cmd_ready_o (m0_cmd_ready),
    .m0_cmd_read_i  (m0_cmd_read),
    .m0_cmd_addr_i  (m0_cmd_addr),
    .m0_cmd_wdata_i (m0_cmd_wdata),
    .m0_cmd_wmask_i (m0_cmd_wmask),
    .m0_rsp_valid_o (m0_rsp_valid),
    .m0_rsp_ready_i (m0_rsp_ready),
    .m0_rsp_rdata_o (m0_rsp_rdata),
    .m1_cmd_valid_i (m1_cmd_valid),
    .m1_cmd_ready_o (m1_cmd_ready),
    .m1_cmd_read_i  (m1_cmd_read),
    .m1_cmd_addr_i  (m1_cmd_addr),
    .m1_cmd_wdata_i (m1_cmd_wdata),
    .m1_cmd_wmask_i (m1_cmd_wmask),
    .m1_rsp_valid_o (m1_rsp_valid),
    .m1_rsp_ready_i (m1_rsp_ready),
    .m1_rsp_rdata_o (m1_rsp_rdata),
    .ram_we_o       (ram_we),
    .ram_addr_o     (ram_addr),
    .ram_din_o      (ram_din),
    .ram_wem_o      (ram_wem),
    .ram_dout_i     (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro: synchronous read, byte-masked write, read-before-write.
  bit [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
    ram_dout <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: golden memory, queue of owed responses, loss count.
  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  bit [31:0]   gold [0:63];
  rsp_t        pend [$];
  int          losses = 0;
  int          cyc = 0;
  logic [13:0] last_addr = '0;
  logic        act_rdy0, act_rdy1;

  task automatic sample();
    bit          slot, e0, e1, a0, a1, ev0, ev1, rd, rr_own;
    logic [13:0] ad;
    logic [31:0] wd;
    logic [3:0]  wm;
    rsp_t        p, n;
    @(negedge clk);
    act_rdy0 = m0_cmd_ready;
    act_rdy1 = m1_cmd_ready;
    if (rst) begin
      chk("rst_rdy0", m0_cmd_ready, 1'b0);
      chk("rst_rdy1", m1_cmd_ready, 1'b0);
      chk("rst_rv0", m0_rsp_valid, 1'b0);
      chk("rst_rv1", m1_rsp_valid, 1'b0);
      chk("rst_we", ram_we, 1'b0);
      chk("rst_wem", ram_wem, 4'h0);
      pend.delete();
      losses    = 0;
      last_addr = '0;
    end else begin
      ev0 = 1'b0;
      ev1 = 1'b0;
      rr_own = 1'b0;
      if (pend.size() > 0) begin
        p      = pend[0];
        ev0    = !p.owner;
        ev1    = p.owner;
        rr_own = p.owner ? m1_rsp_ready : m0_rsp_ready;
      end
      // A slot opens if nothing is owed, or the owed response is fresh and taken now.
      slot = (pend.size() == 0) || (p.cyc == cyc - 1 && rr_own);
      e0   = slot && !(m1_cmd_valid && losses == STARVE_MAX);
      e1   = slot && (!m0_cmd_valid || losses == STARVE_MAX);
      chk("m_rdy0", m0_cmd_ready, e0);
      chk("m_rdy1", m1_cmd_ready, e1);
      chk("m_rv0", m0_rsp_valid, ev0);
      chk("m_rv1", m1_rsp_valid, ev1);
      if (ev0) chk("m_rdata0", m0_rsp_rdata, p.data);
      if (ev1) chk("m_rdata1", m1_rsp_rdata, p.data);
      a0 = m0_cmd_valid && e0;
      a1 = m1_cmd_valid && e1;
      rd = a1 ? m1_cmd_read : m0_cmd_read;
      ad = a1 ? m1_cmd_addr : m0_cmd_addr;
      wd = a1 ? m1_cmd_wdata : m0_cmd_wdata;
      wm = a1 ? m1_cmd_wmask : m0_cmd_wmask;
      chk("m_we", ram_we, (a0 || a1) && !rd);
      if (a0 || a1) begin
        chk("m_addr", ram_addr, ad);
        chk("m_wem", ram_wem, rd ? 4'h0 : wm);
        if (!rd) chk("m_din", ram_din, wd);
        last_addr = ad;
      end else begin
        chk("m_idle_addr", ram_addr, last_addr);
        chk("m_idle_wem", ram_wem, 4'h0);
      end
      if (pend.size() > 0 && rr_own) void'(pend.pop_front());
      if (m0_cmd_valid && m1_cmd_valid && slot && a0) begin
        losses = (losses < STARVE_MAX) ? losses + 1 : STARVE_MAX;
      end else if (a1 || !m1_cmd_valid) begin
        losses = 0;
      end
      if (a0 || a1) begin
        n.owner = a1;
        n.cyc   = cyc;
        if (rd) begin
          n.data = gold[ad[5:0]];
        end else begin
          n.data = 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (wm[b]) gold[ad[5:0]][8*b +: 8] = wd[8*b +: 8];
          end
        end
        pend.push_back(n);
      end
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic rd0, input logic [13:0] a0,
                       input logic [31:0] d0, input logic [3:0] mk0,
                       input logic v1, input logic rd1, input logic [13:0] a1,
                       input logic [31:0] d1, input logic [3:0] mk1,
                       input logic rr0, input logic rr1);
    m0_cmd_valid = v0;  m0_cmd_read = rd0; m0_cmd_addr = a0;
    m0_cmd_wdata = d0;  m0_cmd_wmask = mk0;
    m1_cmd_valid = v1;  m1_cmd_read = rd1; m1_cmd_addr = a1;
    m1_cmd_wdata = d1;  m1_cmd_wmask = mk1;
    m0_rsp_ready = rr0; m1_rsp_ready = rr1;
  endtask

  typedef struct {
    logic        v0, rd0;
    logic [13:0] a0;
    logic [31:0] d0;
    logic [3:0]  mk0;
    logic        v1, rd1;
    logic [13:0] a1;
    logic        rr0, rr1;
    logic        e_rdy0, e_rdy1, e_rv0, e_rv1;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [31:0] sd;
    // Write/read, byte mask, then port-1 read parked for 5 cycles while port 0 waits.
    vecs[0]  = '{1'b1, 1'b0, 14'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 14'h10, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 14'h3, 32'h11223344, 4'hF, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 14'h3, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 14'h3, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1, 14'h10,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int i = 8; i <= 12; i++) begin
      vecs[i] = '{1'b1, 1'b1, 14'h3, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    end
    vecs[13] = '{1'b1, 1'b1, 14'h3, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[14] = '{1'b1, 1'b1, 14'h3, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[16] = '{1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    // Reset with both ports requesting: nothing may be accepted.
    rst = 1'b1;
    drive(1'b1, 1'b1, 14'h1, 32'h0, 4'h0, 1'b1, 1'b1, 14'h2, 32'h0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_addr", ram_addr, 14'h0);
      chk("rst_din", ram_din, 32'h0);
      chk("rst_rdata0", m0_rsp_rdata, 32'h0);
      chk("rst_rdata1", m1_rsp_rdata, 32'h0);
      advance();
    end
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v0, vecs[i].rd0, vecs[i].a0, vecs[i].d0, vecs[i].mk0,
            vecs[i].v1, vecs[i].rd1, vecs[i].a1, 32'h0, 4'h0, vecs[i].rr0, vecs[i].rr1);
      sample();
      chk($sformatf("vec%0d_rdy0", i), m0_cmd_ready, vecs[i].e_rdy0);
      chk($sformatf("vec%0d_rdy1", i), m1_cmd_ready, vecs[i].e_rdy1);
      chk($sformatf("vec%0d_rv0", i), m0_rsp_valid, vecs[i].e_rv0);
      chk($sformatf("vec%0d_rv1", i), m1_rsp_valid, vecs[i].e_rv1);
      if (vecs[i].e_rv0) chk($sformatf("vec%0d_rdata0", i), m0_rsp_rdata, vecs[i].e_dat);
      if (vecs[i].e_rv1) chk($sformatf("vec%0d_rdata1", i), m1_rsp_rdata, vecs[i].e_dat);
      advance();
    end

    // Starvation: both always valid -> grants 0,0,0,0,1 repeating.
    drive(1'b1, 1'b1, 14'h3, 32'h0, 4'h0, 1'b1, 1'b1, 14'h10, 32'h0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      sample();
      chk($sformatf("starve%0d_g1", i), act_rdy1, (i % 5) == 4);
      chk($sformatf("starve%0d_g0", i), act_rdy0, (i % 5) != 4);
      advance();
    end

    // Streaming: 8 writes, then 8 back-to-back reads with one response per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 14'(32 + i), 32'hA5000000 | (i * 32'h111), 4'hF,
            1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
      sample();
      advance();
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, 1'b1, 14'(32 + i), 32'h0, 4'h0,
                       1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
      else drive(1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
      sample();
      if (i < 8) chk($sformatf("stream%0d_rdy", i), m0_cmd_ready, 1'b1);
      if (i > 0) begin
        sd = 32'hA5000000 | ((i - 1) * 32'h111);
        chk($sformatf("stream%0d_rv", i), m0_rsp_valid, 1'b1);
        chk($sformatf("stream%0d_rdata", i), m0_rsp_rdata, sd);
      end
      advance();
    end

    // Reset in the cycle after a read accept: the response is dropped.
    drive(1'b1, 1'b1, 14'h10, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    sample();
    chk("rmid_accept", m0_cmd_ready, 1'b1);
    advance();
    rst = 1'b1;
    drive(1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    #1;
    chk("rmid_rv0_now", m0_rsp_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sample();
      advance();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("rmid_after%0d_rv0", i), m0_rsp_valid, 1'b0);
      advance();
    end
    drive(1'b1, 1'b1, 14'h10, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    sample();
    advance();
    drive(1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    sample();
    chk("rmid_reread_rv0", m0_rsp_valid, 1'b1);
    chk("rmid_reread_data", m0_rsp_rdata, 32'hDEADBEEF);
    advance();

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            $urandom, 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            $urandom, 4'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
